wb_burst_reader: RTL and testbench

- Wishbone pipelined-mode initiator. Reads `cmd_len` consecutive 32-bit words starting at byte address `cmd_addr` and delivers them in order on a valid/ready stream.
- Sits between a loader/DMA-style consumer and word-addressed slaves such as boot ROM and RAM.
- Limits in-flight strobes with a credit scheme so returned data always fits the internal FIFO, even when the consumer back-pressures.

---
 rtl/wb_pkg.sv | 15 +
 rtl/wb_sync_fifo.sv | 62 ++++++
 rtl/wb_burst_reader.sv | 153 +++++++++++++++
 tb/tb_wb_burst_reader.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone burst reader.
// Holds the initiator FSM state encoding and the bus width constants.
package wb_pkg;

  localparam int         WB_ADR_W   = 32;
  localparam int         WB_DAT_W   = 32;
  localparam logic [3:0] WB_SEL_ALL = 4'hF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is visible on rdata while not empty.
// A pop and a push in the same cycle are allowed even when full.
module wb_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push, do_pop;

  assign do_pop  = pop && (count_reg != '0);
  // The pop frees a slot in the same cycle, so a full FIFO can still take a push.
  assign do_push = push && ((count_reg != DEPTH_C) || do_pop);

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;
    always_ff @(posedge clk_i) begin
      if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
        entry_reg <= wdata;
      end
    end
    assign mem_q[gi] = entry_reg;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
    end
  end

  assign rdata = mem_q[rd_ptr_reg];
  assign full  = (count_reg == DEPTH_C);
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone pipelined-mode burst read initiator with credit-limited strobes and a stream output.
// Define WB_TIMEOUT_EN to enable the ack watchdog that aborts a stuck burst and pulses err_o.
module wb_burst_reader
  import wb_pkg::*;
#(
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [31:0]         cmd_addr_i,
  input  logic [LEN_W-1:0]    cmd_len_i,
  output logic                rd_valid_o,
  input  logic                rd_ready_i,
  output logic [31:0]         rd_data_o,
  output logic                rd_last_o,
  output logic                busy_o,
  output logic                err_o,
  output logic                wb_cyc_o,
  output logic                wb_stb_o,
  output logic                wb_we_o,
  output logic [3:0]          wb_sel_o,
  output logic [31:0]         wb_adr_o,
  output logic [31:0]         wb_dat_o,
  input  logic [31:0]         wb_dat_i,
  input  logic                wb_ack_i,
  input  logic                wb_stall_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("wb_burst_reader: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  wb_state_e             state_reg, state_next;
  logic [WB_ADR_W-1:0]   addr_reg;
  logic [LEN_W-1:0]      remaining_reg, len_reg, ack_cnt_reg;
  logic [CNT_W-1:0]      outstanding_reg, fifo_count;
  logic                  accept, issue, ack_valid, abort, credit_ok;
  logic                  fifo_full, fifo_empty, fifo_pop, fifo_push;
  logic [WB_DAT_W:0]     fifo_wdata, fifo_rdata;

  assign accept    = cmd_valid_i && cmd_ready_o && (cmd_len_i != '0);
  assign ack_valid = wb_ack_i && wb_cyc_o;
  // Every strobe in flight owns a FIFO slot, so acks can never overflow the FIFO.
  assign credit_ok = !fifo_full && ((outstanding_reg + fifo_count) < CNT_W'(FIFO_DEPTH));

`ifdef WB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);
  logic [WD_W-1:0] wd_cnt_reg;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_cnt_reg <= '0;
    end else if (abort || ack_valid || (outstanding_reg == '0)) begin
      wd_cnt_reg <= '0;
    end else begin
      wd_cnt_reg <= wd_cnt_reg + 1'b1;
    end
  end

  assign abort = (wd_cnt_reg == WD_W'(TIMEOUT));
`else
  assign abort = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    wb_cyc_o   = (state_reg != IDLE);
    wb_stb_o   = (state_reg == REQ) && (remaining_reg != '0) && credit_ok && !abort;
    issue      = wb_stb_o && !wb_stall_i;
    unique case (state_reg)
      IDLE: if (accept) state_next = REQ;
      REQ:  if (issue && (remaining_reg == LEN_W'(1))) state_next = WAIT;
      // Leave on the edge that retires the final ack so cyc drops right after it.
      WAIT: if ((outstanding_reg == '0) || ((outstanding_reg == CNT_W'(1)) && ack_valid))
              state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_reg        <= '0;
      remaining_reg   <= '0;
      len_reg         <= '0;
      ack_cnt_reg     <= '0;
      outstanding_reg <= '0;
    end else begin
      if (accept) begin
        addr_reg      <= cmd_addr_i & ~32'd3;
        remaining_reg <= cmd_len_i;
        len_reg       <= cmd_len_i;
        ack_cnt_reg   <= '0;
      end else begin
        if (issue) begin
          addr_reg      <= addr_reg + 32'd4;
          remaining_reg <= remaining_reg - 1'b1;
        end
        if (ack_valid) ack_cnt_reg <= ack_cnt_reg + 1'b1;
      end
      if (abort) begin
        outstanding_reg <= '0;
        remaining_reg   <= '0;
      end else begin
        outstanding_reg <= outstanding_reg + CNT_W'(issue) - CNT_W'(ack_valid);
      end
    end
  end

  // Acks return in order, so the ack index is the pop index of that word.
  assign fifo_push  = ack_valid && !abort;
  assign fifo_wdata = {(ack_cnt_reg == len_reg - 1'b1), wb_dat_i};
  assign fifo_pop   = !fifo_empty && rd_ready_i;

  wb_sync_fifo #(
    .WIDTH (WB_DAT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .flush  (abort),
    .push   (fifo_push),
    .wdata  (fifo_wdata),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  assign rd_valid_o  = !fifo_empty;
  assign rd_data_o   = fifo_empty ? '0 : fifo_rdata[WB_DAT_W-1:0];
  assign rd_last_o   = !fifo_empty && fifo_rdata[WB_DAT_W];
  assign cmd_ready_o = (state_reg == IDLE);
  assign busy_o      = (state_reg != IDLE);
  assign err_o       = abort;
  assign wb_adr_o    = addr_reg;
  assign wb_we_o     = 1'b0;
  assign wb_sel_o    = WB_SEL_ALL;
  assign wb_dat_o    = '0;

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed self-checking bench for wb_burst_reader against a single-cycle-ack ROM slave.
// Build with WB_TIMEOUT_EN defined to also exercise the ack watchdog.
`timescale 1ns/1ps
module tb_wb_burst_reader;

  localparam int LEN_W      = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 16;

  logic              clk_i       = 1'b0;
  logic              rst_ni      = 1'b0;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic [31:0]       cmd_addr_i  = '0;
  logic [LEN_W-1:0]  cmd_len_i   = '0;
  logic              rd_valid_o;
  logic              rd_ready_i  = 1'b1;
  logic [31:0]       rd_data_o;
  logic              rd_last_o, busy_o, err_o;
  logic              wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]        wb_sel_o;
  logic [31:0]       wb_adr_o, wb_dat_o;
  logic [31:0]       wb_dat_i    = '0;
  logic              wb_ack_i    = 1'b0;
  logic              wb_stall_i  = 1'b0;
  logic              no_ack      = 1'b0;

  int checks   = 0;
  int failures = 0;
  int strobes  = 0;
  int acks     = 0;
  int err_seen = 0;
  logic [31:0] got_data[$];
  logic        got_last[$];
  logic [31:0] stb_adr[$];

  always #5 clk_i = ~clk_i;

  wb_burst_reader #(
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_len_i   (cmd_len_i),
    .rd_valid_o  (rd_valid_o),
    .rd_ready_i  (rd_ready_i),
    .rd_data_o   (rd_data_o),
    .rd_last_o   (rd_last_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_stb_o    (wb_stb_o),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_stall_i  (wb_stall_i)
  );

  // ROM slave: word i holds 0x1000 + i, acked one cycle after the strobe is taken.
  always @(posedge clk_i) begin
    wb_ack_i <= wb_cyc_o && wb_stb_o && !wb_stall_i && !no_ack;
    wb_dat_i <= 32'h1000 + (wb_adr_o >> 2);
  end

  always @(negedge clk_i) begin
    if (rd_valid_o && rd_ready_i) begin
      got_data.push_back(rd_data_o);
      got_last.push_back(rd_last_o);
      $display("[%0t] pop    data=%08h last=%0b", $time, rd_data_o, rd_last_o);
    end
    if (wb_stb_o && !wb_stall_i) begin
      strobes++;
      stb_adr.push_back(wb_adr_o);
      $display("[%0t] strobe adr=%08h", $time, wb_adr_o);
    end
    if (wb_ack_i && wb_cyc_o) acks++;
    if (err_o) begin
      err_seen++;
      $display("[%0t] watchdog abort pulse", $time);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout simulation ran past its time limit");
    $fatal(1, "global timeout");
  end

  task automatic clear_log();
    got_data.delete();
    got_last.delete();
    stb_adr.delete();
    strobes = 0;
    acks    = 0;
  endtask

  task automatic send_cmd(input logic [31:0] addr, input logic [LEN_W-1:0] len);
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b1;
    cmd_addr_i  = addr;
    cmd_len_i   = len;
    @(posedge clk_i); #1;
    cmd_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk_i); #1;
      n++;
    end while ((busy_o || rd_valid_o) && n < 300);
    checks++;
    if (busy_o || rd_valid_o) begin
      failures++;
      $display("FAIL %s_drain busy=%0b valid=%0b after %0d cycles, required both 0", name, busy_o, rd_valid_o, n);
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    #1;
    checks++;
    if (cmd_ready_o !== 1'b1 || busy_o !== 1'b0 || err_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl ready=%0b busy=%0b err=%0b, required 1 0 0", cmd_ready_o, busy_o, err_o);
    end
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || wb_adr_o !== 32'h0 || wb_we_o !== 1'b0 || wb_dat_o !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus cyc=%0b stb=%0b adr=%08h we=%0b dat=%08h, required all 0", wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o, wb_dat_o);
    end
    checks++;
    if (rd_valid_o !== 1'b0 || rd_data_o !== 32'h0 || rd_last_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_stream valid=%0b data=%08h last=%0b, required all 0", rd_valid_o, rd_data_o, rd_last_o);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_basic();
    int n;
    clear_log();
    rd_ready_i = 1'b1;
    send_cmd(32'h0000_0013, 8'd4);
    @(negedge clk_i); #1;
    checks++;
    if (wb_stb_o !== 1'b1 || wb_adr_o !== 32'h10 || rd_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_first_strobe stb=%0b adr=%08h valid=%0b, required 1 00000010 0", wb_stb_o, wb_adr_o, rd_valid_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (rd_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid valid=%0b two cycles after accept, required 0", rd_valid_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h1004) begin
      failures++;
      $display("FAIL basic_latency valid=%0b data=%08h, required 1 00001004", rd_valid_o, rd_data_o);
    end
    n = 0;
    while (acks < 4 && n < 50) begin
      @(negedge clk_i); #1;
      n++;
    end
    checks++;
    if (acks !== 4 || wb_cyc_o !== 1'b1) begin
      failures++;
      $display("FAIL basic_final_ack acks=%0d cyc=%0b, required 4 1", acks, wb_cyc_o);
    end
    @(negedge clk_i); #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_cyc_drop cyc=%0b busy=%0b one cycle after final ack, required 0 0", wb_cyc_o, busy_o);
    end
    wait_drain("basic");
    checks++;
    if (strobes !== 4) begin
      failures++;
      $display("FAIL basic_strobes got=%0d, required 4", strobes);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== 32'h1004 + i || got_last[i] !== (i == 3) ||
          stb_adr[i] !== 32'h10 + 4 * i) begin
        failures++;
        $display("FAIL basic_word%0d data=%08h last=%0b adr=%08h (n=%0d), required %08h %0b %08h",
                 i, got_data[i], got_last[i], stb_adr[i], got_data.size(), 32'h1004 + i, (i == 3), 32'h10 + 4 * i);
      end
    end
  endtask

  task automatic test_backpressure();
    clear_log();
    rd_ready_i = 1'b0;
    send_cmd(32'h40, 8'd8);
    repeat (10) @(negedge clk_i);
    #1;
    checks++;
    if (strobes !== FIFO_DEPTH || got_data.size() !== 0) begin
      failures++;
      $display("FAIL bp_credit strobes=%0d popped=%0d, required %0d 0", strobes, got_data.size(), FIFO_DEPTH);
    end
    checks++;
    if (rd_valid_o !== 1'b1 || rd_data_o !== 32'h1010) begin
      failures++;
      $display("FAIL bp_head valid=%0b data=%08h, required 1 00001010", rd_valid_o, rd_data_o);
    end
    @(posedge clk_i); #1;
    rd_ready_i = 1'b1;
    wait_drain("bp");
    checks++;
    if (strobes !== 8) begin
      failures++;
      $display("FAIL bp_strobes got=%0d, required 8", strobes);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== 32'h1010 + i || got_last[i] !== (i == 7)) begin
        failures++;
        $display("FAIL bp_word%0d data=%08h last=%0b (n=%0d), required %08h %0b",
                 i, got_data[i], got_last[i], got_data.size(), 32'h1010 + i, (i == 7));
      end
    end
  endtask

  task automatic test_stall();
    int          n;
    logic        held;
    logic [31:0] held_adr;
    clear_log();
    send_cmd(32'h100, 8'd5);
    wb_stall_i = 1'b1;
    held       = 1'b0;
    held_adr   = '0;
    n          = 0;
    do begin
      @(negedge clk_i); #1;
      if (held) begin
        checks++;
        if (wb_stb_o !== 1'b1 || wb_adr_o !== held_adr) begin
          failures++;
          $display("FAIL stall_hold stb=%0b adr=%08h after stall, required 1 %08h", wb_stb_o, wb_adr_o, held_adr);
        end
      end
      held     = wb_stb_o && wb_stall_i;
      held_adr = wb_adr_o;
      @(posedge clk_i); #1;
      wb_stall_i = ~wb_stall_i;
      n++;
    end while ((busy_o || rd_valid_o) && n < 80);
    wb_stall_i = 1'b0;
    wait_drain("stall");
    checks++;
    if (strobes !== 5) begin
      failures++;
      $display("FAIL stall_strobes got=%0d, required 5", strobes);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== 32'h1040 + i || got_last[i] !== (i == 4) ||
          stb_adr[i] !== 32'h100 + 4 * i) begin
        failures++;
        $display("FAIL stall_word%0d data=%08h last=%0b adr=%08h (n=%0d), required %08h %0b %08h",
                 i, got_data[i], got_last[i], stb_adr[i], got_data.size(), 32'h1040 + i, (i == 4), 32'h100 + 4 * i);
      end
    end
  endtask

  task automatic test_zero_len();
    clear_log();
    send_cmd(32'h20, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i); #1;
      checks++;
      if (wb_cyc_o !== 1'b0 || rd_valid_o !== 1'b0 || cmd_ready_o !== 1'b1 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL zero_len_c%0d cyc=%0b valid=%0b ready=%0b busy=%0b, required 0 0 1 0",
                 i, wb_cyc_o, rd_valid_o, cmd_ready_o, busy_o);
      end
    end
    checks++;
    if (strobes !== 0) begin
      failures++;
      $display("FAIL zero_len_strobes got=%0d, required 0", strobes);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    clear_log();
    send_cmd(32'h0, 8'd8);
    n = 0;
    while (acks < 2 && n < 50) begin
      @(negedge clk_i); #1;
      n++;
    end
    rst_ni = 1'b0;
    #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || rd_valid_o !== 1'b0 || busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_abort cyc=%0b stb=%0b valid=%0b busy=%0b ready=%0b, required 0 0 0 0 1",
               wb_cyc_o, wb_stb_o, rd_valid_o, busy_o, cmd_ready_o);
    end
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    clear_log();
    send_cmd(32'h0, 8'd2);
    wait_drain("rst_mid");
    checks++;
    if (strobes !== 2 || got_data.size() !== 2) begin
      failures++;
      $display("FAIL rst_mid_count strobes=%0d words=%0d, required 2 2", strobes, got_data.size());
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== 32'h1000 + i || got_last[i] !== (i == 1)) begin
        failures++;
        $display("FAIL rst_mid_word%0d data=%08h last=%0b, required %08h %0b",
                 i, got_data[i], got_last[i], 32'h1000 + i, (i == 1));
      end
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    clear_log();
    err_seen = 0;
    no_ack   = 1'b1;
    send_cmd(32'h0, 8'd8);
    n = 0;
    while (strobes == 0 && n < 20) begin
      @(negedge clk_i); #1;
      n++;
    end
    n = 0;
    do begin
      @(negedge clk_i); #1;
      n++;
    end while (!err_o && n < 60);
    checks++;
    if (err_o !== 1'b1 || n !== TIMEOUT + 1) begin
      failures++;
      $display("FAIL timeout_pulse err=%0b at cycle %0d after first strobe, required 1 at %0d", err_o, n, TIMEOUT + 1);
    end
    @(negedge clk_i); #1;
    checks++;
    if (wb_cyc_o !== 1'b0 || busy_o !== 1'b0 || err_o !== 1'b0 || rd_valid_o !== 1'b0 || cmd_ready_o !== 1'b1) begin
      failures++;
      $display("FAIL timeout_after cyc=%0b busy=%0b err=%0b valid=%0b ready=%0b, required 0 0 0 0 1",
               wb_cyc_o, busy_o, err_o, rd_valid_o, cmd_ready_o);
    end
    checks++;
    if (err_seen !== 1) begin
      failures++;
      $display("FAIL timeout_pulse_width pulses=%0d, required 1", err_seen);
    end
    no_ack = 1'b0;
    clear_log();
    send_cmd(32'h8, 8'd2);
    wait_drain("timeout_recover");
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== 32'h1002 + i || got_last[i] !== (i == 1)) begin
        failures++;
        $display("FAIL timeout_recover_word%0d data=%08h last=%0b, required %08h %0b",
                 i, got_data[i], got_last[i], 32'h1002 + i, (i == 1));
      end
    end
  endtask
`else
  task automatic test_no_err();
    checks++;
    if (err_seen !== 0) begin
      failures++;
      $display("FAIL no_err pulses=%0d with watchdog disabled, required 0", err_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_zero_len();
    test_reset_mid();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`else
    test_no_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
